// File: rtl/mem_slave_responder_if.sv
// mem_slave_responder_if
// Bus between the MAC bus master and the memory slave responder.
// Ports (signals carried by the interface):
//   AS_N          master -> slave  address strobe, active-low
//   WR_N          master -> slave  0 = write, 1 = read
//   ADDR          master -> slave  word address (ADDR_W bits)
//   DI            master -> slave  write data (DATA_W bits)
//   DO            slave -> master  registered read data (DATA_W bits)
//   ACK_N         slave -> master  one-cycle acknowledge, active-low
//   SLV_STATE_OUT slave -> master  slave state encoding for trace/debug
interface mem_slave_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              AS_N;
    logic              WR_N;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic              ACK_N;
    logic [1:0]        SLV_STATE_OUT;

    modport master (
        output AS_N, WR_N, ADDR, DI,
        input  DO, ACK_N, SLV_STATE_OUT
    );

    modport slave (
        input  AS_N, WR_N, ADDR, DI,
        output DO, ACK_N, SLV_STATE_OUT
    );
endinterface

// File: rtl/mem_slave_responder.sv
// mem_slave_responder
// Bus slave sitting downstream of the MAC bus master. It captures a request
// while AS_N is low, waits WAIT_STATES extra cycles, performs the word access
// on a 2^ADDR_W x DATA_W memory and pulses ACK_N low for exactly one cycle.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active-low
//   bus    slave modport of mem_slave_responder_if (AS_N, WR_N, ADDR, DI in;
//          DO, ACK_N, SLV_STATE_OUT out)
module mem_slave_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input logic                  clk,
    input logic                  reset,
    mem_slave_responder_if.slave bus
);

    // The wait counter is 4 bits wide, so anything outside 0..15 cannot be honoured.
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_slave_responder: WAIT_STATES must be within 0..15");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE    = 2'h0,
        WAIT    = 2'h1,
        ACK     = 2'h2,
        RELEASE = 2'h3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              capture;
    logic              commit;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_n_q;
    logic [DATA_W-1:0] do_q;
    logic              ack_n_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. capture marks the edge a request is latched from IDLE;
    // commit marks the edge the memory access happens (the edge entering ACK).
    // RELEASE holds until the strobe drops so a lingering AS_N is never taken
    // as a second request.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.AS_N) begin
                    capture    = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.AS_N) begin
                    next_state = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    commit     = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = RELEASE;
            end
            RELEASE: begin
                if (bus.AS_N) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latches and wait counter. Only the values present at capture
    // matter; later bus changes do not touch the access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            wr_n_q   <= 1'b0;
            wait_cnt <= 4'd0;
        end else if (capture) begin
            addr_q   <= bus.ADDR;
            data_q   <= bus.DI;
            wr_n_q   <= bus.WR_N;
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && !bus.AS_N && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Registered outputs. ACK_N is decoded from the next state so that it is
    // low exactly while the state register holds ACK. DO only moves on a
    // completed read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_n_q <= 1'b1;
            do_q    <= '0;
        end else begin
            ack_n_q <= (next_state != ACK);
            if (commit && wr_n_q) begin
                do_q <= mem[addr_q];
            end
        end
    end

    // Memory array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (commit && !wr_n_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.DO            = do_q;
    assign bus.ACK_N         = ack_n_q;
    assign bus.SLV_STATE_OUT = state;

endmodule
